// File: rtl/output_buf_ctrl_if.sv
// Purpose: bundles the output-buffer controller's handshake, address and status signals.
// Ports:   master = controller side (drives buffer control, drain address, status);
//          slave  = PE array / downstream side (drives pe_done and out_ready).
interface output_buf_ctrl_if #(
    parameter int ROWS = 4,
    parameter int COLS = 8
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    logic          pe_done;
    logic          out_ready;
    logic          buf_en;
    logic          buf_select;
    logic [RW-1:0] rd_row;
    logic [CW-1:0] rd_col;
    logic          out_valid;
    logic          tile_done;
    logic          busy;
    logic          overflow;
    logic [15:0]   tile_count;

    modport master (
        input  pe_done, out_ready,
        output buf_en, buf_select, rd_row, rd_col, out_valid,
               tile_done, busy, overflow, tile_count
    );

    modport slave (
        output pe_done, out_ready,
        input  buf_en, buf_select, rd_row, rd_col, out_valid,
               tile_done, busy, overflow, tile_count
    );
endinterface

// File: rtl/output_buf_ctrl.sv
// Purpose: sequences loading of the PE-array output buffer (FILL) and drains it word by word (DRAIN).
// Latency: pe_done at cycle t -> buf_en t+1..t+PIPE_DEPTH -> out_valid from t+PIPE_DEPTH+1; all outputs registered/Moore.
// Backpressure: drain index and out_valid hold while out_ready=0; one pe_done may wait as pending, a further one sets sticky overflow.
// Ports: clk, reset (synchronous, active-high), bus (output_buf_ctrl_if.master).
// Build option: define OUTBUF_CTRL_TILE_CNT_EN to enable the 16-bit tile counter; otherwise tile_count is tied to 0.
module output_buf_ctrl #(
    parameter int N          = 17,
    parameter int PIPE_DEPTH = 3,
    parameter int ROWS       = 4,
    parameter int COLS       = 8
) (
    input  logic               clk,
    input  logic               reset,
    output_buf_ctrl_if.master  bus
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int FW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

    // N describes the downstream buffer word; it only needs to be sane here.
    if (N < 1 || PIPE_DEPTH < 1 || ROWS < 1 || COLS < 1) begin : g_param_check
        $error("output_buf_ctrl: N, PIPE_DEPTH, ROWS and COLS must all be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_nxt;
    logic [FW-1:0] fill_cnt_q, fill_cnt_nxt;
    logic [RW-1:0] row_q, row_nxt;
    logic [CW-1:0] col_q, col_nxt;
    logic          pending_q, pending_nxt;
    logic          overflow_q, overflow_nxt;
    logic          sel_q, sel_nxt;
    logic          tile_done_q, tile_done_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            fill_cnt_q  <= '0;
            row_q       <= '0;
            col_q       <= '0;
            pending_q   <= 1'b0;
            overflow_q  <= 1'b0;
            sel_q       <= 1'b0;
            tile_done_q <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            fill_cnt_q  <= fill_cnt_nxt;
            row_q       <= row_nxt;
            col_q       <= col_nxt;
            pending_q   <= pending_nxt;
            overflow_q  <= overflow_nxt;
            sel_q       <= sel_nxt;
            tile_done_q <= tile_done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state_q;
        fill_cnt_nxt  = fill_cnt_q;
        row_nxt       = row_q;
        col_nxt       = col_q;
        pending_nxt   = pending_q;
        overflow_nxt  = overflow_q;
        sel_nxt       = sel_q;
        tile_done_nxt = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.pe_done) begin
                    state_nxt    = FILL;
                    fill_cnt_nxt = '0;
                end
            end
            FILL: begin
                if (fill_cnt_q == FW'(PIPE_DEPTH - 1)) begin
                    state_nxt    = DRAIN;
                    fill_cnt_nxt = '0;
                    // Swap banks as the freshly loaded bank becomes the drain source.
                    sel_nxt      = ~sel_q;
                end else begin
                    fill_cnt_nxt = fill_cnt_q + FW'(1);
                end
            end
            DRAIN: begin
                if (bus.out_ready) begin
                    if (col_q == CW'(COLS - 1)) begin
                        col_nxt = '0;
                        if (row_q == RW'(ROWS - 1)) begin
                            row_nxt       = '0;
                            tile_done_nxt = 1'b1;
                            // A waiting or simultaneous tile goes straight back to FILL.
                            if (pending_q || bus.pe_done) begin
                                state_nxt    = FILL;
                                fill_cnt_nxt = '0;
                            end else begin
                                state_nxt = IDLE;
                            end
                        end else begin
                            row_nxt = row_q + RW'(1);
                        end
                    end else begin
                        col_nxt = col_q + CW'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Only one tile can wait; a second arrival while one waits is lost.
        if (state_q != IDLE && bus.pe_done) begin
            if (pending_q) begin
                overflow_nxt = 1'b1;
            end else begin
                pending_nxt = 1'b1;
            end
        end

        // Entering FILL consumes the waiting tile (or the one arriving this cycle).
        if (state_nxt == FILL && state_q != FILL) begin
            pending_nxt = 1'b0;
        end
    end

    assign bus.buf_en     = (state_q == FILL);
    assign bus.out_valid  = (state_q == DRAIN);
    assign bus.busy       = (state_q != IDLE);
    assign bus.buf_select = sel_q;
    assign bus.tile_done  = tile_done_q;
    assign bus.overflow   = overflow_q;
    assign bus.rd_row     = (state_q == DRAIN) ? row_q : '0;
    assign bus.rd_col     = (state_q == DRAIN) ? col_q : '0;

`ifdef OUTBUF_CTRL_TILE_CNT_EN
    logic [15:0] tile_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            tile_cnt_q <= '0;
        end else if (tile_done_nxt) begin
            tile_cnt_q <= tile_cnt_q + 16'd1;
        end
    end

    assign bus.tile_count = tile_cnt_q;
`else
    assign bus.tile_count = '0;
`endif
endmodule

// File: tb/tb_output_buf_ctrl.sv
module tb_output_buf_ctrl;
    localparam int ROWS  = 4;
    localparam int COLS  = 8;
    localparam int PD    = 3;
    localparam int WORDS = ROWS * COLS;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    output_buf_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    output_buf_ctrl #(.N(17), .PIPE_DEPTH(PD), .ROWS(ROWS), .COLS(COLS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int td_seen  = 0;

    // Reference model: phase + remaining fill cycles + linear word number.
    int m_mode;   // 0 idle, 1 fill, 2 drain
    int m_fill;
    int m_k;
    int m_tiles;
    bit m_pend, m_ovf, m_sel, m_td;

    function automatic void model_step(bit r, bit pe, bit rdy);
        int old;
        bit go_fill;
        if (r) begin
            m_mode = 0; m_fill = 0; m_k = 0; m_tiles = 0;
            m_pend = 0; m_ovf = 0; m_sel = 0; m_td = 0;
            return;
        end
        old = m_mode;
        go_fill = 0;
        m_td = 0;
        if (old == 0) begin
            if (pe) go_fill = 1;
        end else if (old == 1) begin
            m_fill = m_fill - 1;
            if (m_fill == 0) begin
                m_mode = 2;
                m_sel  = !m_sel;
                m_k    = 0;
            end
        end else if (rdy) begin
            m_k = m_k + 1;
            if (m_k == WORDS) begin
                m_k = 0;
                m_td = 1;
                m_tiles = m_tiles + 1;
                if (m_pend || pe) go_fill = 1;
                else m_mode = 0;
            end
        end
        if (old != 0 && pe) begin
            if (m_pend) m_ovf = 1;
            else m_pend = 1;
        end
        if (go_fill) begin
            m_mode = 1;
            m_fill = PD;
            m_pend = 0;
        end
    endfunction

    function automatic logic [26:0] model_obs();
        logic [1:0]  r;
        logic [2:0]  c;
        logic [15:0] tc;
        r = (m_mode == 2) ? 2'(m_k / COLS) : 2'd0;
        c = (m_mode == 2) ? 3'(m_k % COLS) : 3'd0;
`ifdef OUTBUF_CTRL_TILE_CNT_EN
        tc = 16'(m_tiles);
`else
        tc = 16'd0;
`endif
        return {m_mode == 1, m_sel, m_mode == 2, m_td, m_mode != 0, m_ovf, r, c, tc};
    endfunction

    function automatic logic [26:0] dut_obs();
        return {bus.buf_en, bus.buf_select, bus.out_valid, bus.tile_done, bus.busy,
                bus.overflow, bus.rd_row, bus.rd_col, bus.tile_count};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One clock: apply inputs, advance the model, sample #1 after the edge.
    task automatic tick(input bit r, input bit pe, input bit rdy);
        reset         = r;
        bus.pe_done   = pe;
        bus.out_ready = rdy;
        @(posedge clk);
        model_step(r, pe, rdy);
        #1;
        check("model", {5'd0, dut_obs()}, {5'd0, model_obs()});
        if (bus.tile_done === 1'b1) td_seen++;
        reset       = 1'b0;
        bus.pe_done = 1'b0;
    endtask

    typedef struct packed {
        logic rst, pe, rdy;
        logic en, sel, vld, td, busy, ovf;
        logic [1:0] row;
        logic [2:0] col;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int acc;
        int en_cnt;
        logic [10:0] got;
        reset         = 1'b1;
        bus.pe_done   = 1'b0;
        bus.out_ready = 1'b0;

        //           rst  pe   rdy  en   sel  vld  td   busy ovf  row   col
        tbl[0]  = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,3'd0};
        tbl[1]  = {1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,2'd0,3'd0};
        tbl[2]  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,2'd0,3'd0};
        tbl[3]  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,2'd0,3'd0};
        tbl[4]  = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,2'd0,3'd0};
        tbl[5]  = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,2'd0,3'd0};
        tbl[6]  = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,2'd0,3'd1};
        tbl[7]  = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,2'd0,3'd2};
        tbl[8]  = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,2'd0,3'd2};
        tbl[9]  = {1'b0,1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,2'd0,3'd3};
        tbl[10] = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,3'd0};
        tbl[11] = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,3'd0};

        for (int i = 0; i < 12; i++) begin
            tick(tbl[i].rst, tbl[i].pe, tbl[i].rdy);
            got = {bus.buf_en, bus.buf_select, bus.out_valid, bus.tile_done,
                   bus.busy, bus.overflow, bus.rd_row, bus.rd_col};
            check($sformatf("table[%0d]", i), {21'd0, got}, {21'd0, tbl[i][10:0]});
        end
        check("reset_tile_count", {16'd0, bus.tile_count}, 32'd0);

        // Single tile, out_ready held high.
        tick(1, 0, 1);
        td_seen = 0;
        en_cnt  = 0;
        tick(0, 1, 1);
        for (int i = 0; i < PD; i++) begin
            if (bus.buf_en === 1'b1) en_cnt++;
            tick(0, 0, 1);
        end
        check("fill_cycles", en_cnt, PD);
        check("sel_toggled", {31'd0, bus.buf_select}, 32'd1);
        for (int i = 0; i < WORDS; i++) begin
            check("drain_addr", {27'd0, bus.out_valid, bus.rd_row, bus.rd_col},
                  {27'd0, 1'b1, 2'(i / COLS), 3'(i % COLS)});
            tick(0, 0, 1);
        end
        check("single_tile_done", {31'd0, bus.tile_done}, 32'd1);
        tick(0, 0, 1);
        check("back_to_idle", {30'd0, bus.busy, bus.tile_done}, 32'd0);

        // out_ready toggling: 64 drain cycles, 32 accepts.
        tick(1, 0, 0);
        tick(0, 1, 0);
        for (int i = 0; i < PD; i++) tick(0, 0, 0);
        acc = 0;
        td_seen = 0;
        for (int i = 0; i < 2 * WORDS; i++) begin
            if (bus.out_valid === 1'b1 && (i % 2) == 0) acc++;
            tick(0, 0, (i % 2) == 0);
        end
        check("toggle_accepts", acc, WORDS);
        check("toggle_tile_done", td_seen, 1);
        check("toggle_idle", {31'd0, bus.busy}, 32'd0);

        // Second pe_done mid-drain: straight back to FILL.
        tick(1, 0, 1);
        tick(0, 1, 1);
        for (int i = 0; i < PD; i++) tick(0, 0, 1);
        for (int i = 0; i < WORDS; i++) tick(0, i == 10, 1);
        check("direct_fill", {29'd0, bus.tile_done, bus.buf_en, bus.busy}, 32'd7);
        for (int i = 0; i < PD; i++) tick(0, 0, 1);
        check("sel_returns", {30'd0, bus.out_valid, bus.buf_select}, 32'd2);

        // Three pe_done during one tile: overflow, two tiles.
        tick(1, 0, 1);
        td_seen = 0;
        tick(0, 1, 1);
        tick(0, 1, 1);
        for (int i = 0; i < 6; i++) tick(0, 0, 1);
        tick(0, 1, 1);
        for (int i = 0; i < 120; i++) tick(0, 0, 1);
        check("overflow_tiles", td_seen, 2);
        check("overflow_sticky", {30'd0, bus.overflow, bus.busy}, 32'd2);

        // Reset mid-drain at index 17, then restart.
        tick(1, 0, 1);
        tick(0, 1, 1);
        for (int i = 0; i < PD; i++) tick(0, 0, 1);
        for (int i = 0; i < 17; i++) tick(0, 0, 1);
        check("mid_index", {27'd0, bus.rd_row, bus.rd_col}, {27'd0, 2'd2, 3'd1});
        tick(1, 0, 1);
        check("mid_reset", {5'd0, dut_obs()}, 32'd0);
        tick(0, 1, 1);
        for (int i = 0; i < PD; i++) tick(0, 0, 1);
        check("restart_addr", {27'd0, bus.out_valid, bus.rd_row, bus.rd_col}, {27'd0, 1'b1, 5'd0});

        // Three tiles and the tile counter.
        tick(1, 0, 1);
        for (int t = 0; t < 3; t++) begin
            tick(0, 1, 1);
            for (int i = 0; i < PD + WORDS + 2; i++) tick(0, 0, 1);
        end
`ifdef OUTBUF_CTRL_TILE_CNT_EN
        check("tile_count", {16'd0, bus.tile_count}, 32'd3);
`else
        check("tile_count", {16'd0, bus.tile_count}, 32'd0);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            tick($urandom_range(0, 599) == 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 9) < 7);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule

// File: doc/output_buf_ctrl.md
OUTPUT_BUF_CTRL -- requirements
Module: output_buf_ctrl

Interface
REQ-001 SHALL have parameter N, default 17: result word width of the downstream output buffer; carried for integration only, unused internally.
REQ-002 SHALL have parameter PIPE_DEPTH, default 3: number of enabled shift cycles needed to load the output buffer.
REQ-003 SHALL have parameter ROWS, default 4: PE array rows.
REQ-004 SHALL have parameter COLS, default 8: PE array columns.
REQ-005 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port pe_done, input, 1 bit: single-cycle pulse meaning a PE array tile result is present.
REQ-008 SHALL have port out_ready, input, 1 bit: downstream accepts the current result word.
REQ-009 SHALL have port buf_en, output, 1 bit: shift enable to the output buffer.
REQ-010 SHALL have port buf_select, output, 1 bit: output buffer bank select.
REQ-011 SHALL have port rd_row, output, clog2(ROWS) bits: row index of the word being drained.
REQ-012 SHALL have port rd_col, output, clog2(COLS) bits: column index of the word being drained.
REQ-013 SHALL have port out_valid, output, 1 bit: rd_row/rd_col address a valid result word.
REQ-014 SHALL have port tile_done, output, 1 bit: one-cycle pulse after the last word of a tile is accepted.
REQ-015 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-016 SHALL have port overflow, output, 1 bit: sticky flag for a lost pe_done.
REQ-017 SHALL have port tile_count, output, 16 bits: count of completed tiles (see Configuration).

Function
REQ-018 SHALL implement the states IDLE, FILL and DRAIN; all outputs are Moore, decoded from registers.
REQ-019 SHALL move IDLE->FILL on the edge where pe_done=1.
REQ-020 SHALL hold buf_en=1 exactly while in FILL, for PIPE_DEPTH consecutive cycles, and 0 otherwise.
REQ-021 SHALL move FILL->DRAIN after the PIPE_DEPTH-th FILL cycle and toggle buf_select on that same edge.
REQ-022 SHALL give latency of pe_done at cycle t -> buf_en high t+1..t+3 -> out_valid=1 from t+4 (defaults).
REQ-023 SHALL hold out_valid=1 throughout DRAIN; rd_row/rd_col start at 0/0; col is the fastest-varying index.
REQ-024 SHALL, in DRAIN, advance the index only on out_valid&out_ready and hold index and out_valid when out_ready=0.
REQ-025 SHALL, on acceptance of index (ROWS-1, COLS-1), pulse tile_done for 1 cycle and wrap the index to 0/0.
REQ-026 SHALL, after that final accept, go to FILL if the pending flag is set or pe_done=1 in the same cycle, else to IDLE.
REQ-027 SHALL set a one-deep pending flag on pe_done in FILL or DRAIN, and clear it on entry to FILL.
REQ-028 SHALL set overflow on pe_done while pending is already set, hold it until reset, and drop that event.
REQ-029 SHALL drive rd_row=rd_col=0 outside DRAIN.

Reset
REQ-030 SHALL, with reset=1 at a clock edge, force IDLE, pending=0 and the index to 0, regardless of the state mid-fill or mid-drain.
REQ-031 SHALL, under that reset, drive buf_en=0, buf_select=0, out_valid=0, tile_done=0, busy=0, overflow=0 and tile_count=0.

Configuration
REQ-032 SHALL, with macro OUTBUF_CTRL_TILE_CNT_EN defined, increment tile_count by 1 on every tile_done, wrapping from 0xFFFF to 0.
REQ-033 SHALL, with OUTBUF_CTRL_TILE_CNT_EN undefined, keep the tile_count port but tie it to 0 with no counter register.

Verification
REQ-034 SHALL cover: reset, single pe_done, out_ready held 1 -> buf_en high 3 cycles, buf_select 0->1, 32 valid words (0,0)..(3,7) on consecutive cycles, then tile_done, then IDLE.
REQ-035 SHALL cover: out_ready toggling 1/0 during DRAIN -> index holds on low cycles; 64 cycles to drain; exactly 32 accepts.
REQ-036 SHALL cover: second pe_done mid-DRAIN -> after tile_done, FILL directly with no IDLE cycle; buf_select returns to 0.
REQ-037 SHALL cover: three pe_done during one tile -> overflow=1 stays set, and only 2 tiles complete.
REQ-038 SHALL cover: reset asserted at drain index 17 -> next cycle all outputs at reset values; a new pe_done restarts from (0,0).
REQ-039 SHALL cover: with OUTBUF_CTRL_TILE_CNT_EN, 3 tiles -> tile_count=3; without the macro -> tile_count=0.
